// File: rtl/clint_timebase.sv
// clint_timebase: timer_clk-domain mtime keeper for the CLINT.
// A fractional num/den divider generates the mtime tick. mtime supports
// load and halt, is compared against NUM_CHANNELS mtimecmp registers, and
// is exported as a Gray-coded copy for the bus-clock front end.
module clint_timebase #(
  parameter int NUM_CHANNELS = 1,
  parameter int TIME_WIDTH   = 64,
  parameter int RATIO_WIDTH  = 16,
  parameter int DEF_NUM      = 1,
  parameter int DEF_DEN      = 40
) (
  input  logic                    timer_clk,
  input  logic                    rstn,
  input  logic                    cfg_wr,
  input  logic [RATIO_WIDTH-1:0]  cfg_num,
  input  logic [RATIO_WIDTH-1:0]  cfg_den,
  input  logic                    halt,
  input  logic                    load_en,
  input  logic [TIME_WIDTH-1:0]   load_data,
  input  logic [NUM_CHANNELS-1:0] cmp_wr,
  input  logic [TIME_WIDTH-1:0]   cmp_data,
  output logic [TIME_WIDTH-1:0]   mtime,
  output logic [TIME_WIDTH-1:0]   mtime_gray,
  output logic                    load_epoch,
  output logic                    tick,
  output logic [NUM_CHANNELS-1:0] mtip
);

  if (NUM_CHANNELS < 1 || NUM_CHANNELS > 4094) begin : g_bad_channels
    $error("clint_timebase: NUM_CHANNELS must be within 1..4094");
  end
  if (DEF_DEN == 0) begin : g_bad_den
    $error("clint_timebase: DEF_DEN must be non-zero");
  end

  localparam logic [RATIO_WIDTH-1:0] NUM_RST = RATIO_WIDTH'(DEF_NUM);
  localparam logic [RATIO_WIDTH-1:0] DEN_RST = RATIO_WIDTH'(DEF_DEN);

  logic [RATIO_WIDTH-1:0] num_q, num_d;
  logic [RATIO_WIDTH-1:0] den_q, den_d;
  logic [RATIO_WIDTH:0]   acc_q, acc_d;
  logic [RATIO_WIDTH:0]   acc_sum;
  logic                   tick_ev;

  logic [TIME_WIDTH-1:0]  mtime_q, mtime_d;
  logic [TIME_WIDTH-1:0]  mtime_gray_q, mtime_gray_d;
  logic                   load_epoch_q, load_epoch_d;
  logic                   tick_q, tick_d;

  logic [TIME_WIDTH-1:0]   mtimecmp_q [NUM_CHANNELS];
  logic [TIME_WIDTH-1:0]   mtimecmp_d [NUM_CHANNELS];
  logic [NUM_CHANNELS-1:0] mtip_q, mtip_d;

  // Fractional divider: ratio config and accumulator stepping.
  // acc stays below den, so acc+num fits in RATIO_WIDTH+1 bits.
  always_comb begin
    num_d   = num_q;
    den_d   = den_q;
    acc_d   = acc_q;
    tick_ev = 1'b0;
    acc_sum = acc_q + {1'b0, num_q};
    if (cfg_wr) begin
      num_d = cfg_num;
      den_d = cfg_den;
      acc_d = '0;
    end else if (!halt) begin
      if (den_q == '0) begin
        acc_d = acc_q;
      end else if (num_q >= den_q) begin
        acc_d   = '0;
        tick_ev = 1'b1;
      end else if (acc_sum >= {1'b0, den_q}) begin
        acc_d   = acc_sum - {1'b0, den_q};
        tick_ev = 1'b1;
      end else begin
        acc_d = acc_sum;
      end
    end
  end

  // mtime update: load beats tick; Gray copy derived from the next value.
  always_comb begin
    mtime_d      = mtime_q;
    load_epoch_d = load_epoch_q;
    tick_d       = 1'b0;
    if (load_en) begin
      mtime_d      = load_data;
      load_epoch_d = ~load_epoch_q;
    end else if (tick_ev) begin
      mtime_d = mtime_q + 1'b1;
      tick_d  = 1'b1;
    end
    mtime_gray_d = mtime_d ^ (mtime_d >> 1);
  end

  // Comparator writes and registered interrupt-pending levels.
  always_comb begin
    for (int unsigned i = 0; i < NUM_CHANNELS; i++) begin
      mtimecmp_d[i] = cmp_wr[i] ? cmp_data : mtimecmp_q[i];
      mtip_d[i]     = (mtimecmp_q[i] <= mtime_q);
    end
  end

  // State registers, asynchronously cleared by rstn.
  always_ff @(posedge timer_clk or negedge rstn) begin
    if (!rstn) begin
      num_q        <= NUM_RST;
      den_q        <= DEN_RST;
      acc_q        <= '0;
      mtime_q      <= '0;
      mtime_gray_q <= '0;
      load_epoch_q <= 1'b0;
      tick_q       <= 1'b0;
      mtip_q       <= '0;
      for (int unsigned i = 0; i < NUM_CHANNELS; i++) begin
        mtimecmp_q[i] <= '1;
      end
    end else begin
      num_q        <= num_d;
      den_q        <= den_d;
      acc_q        <= acc_d;
      mtime_q      <= mtime_d;
      mtime_gray_q <= mtime_gray_d;
      load_epoch_q <= load_epoch_d;
      tick_q       <= tick_d;
      mtip_q       <= mtip_d;
      for (int unsigned i = 0; i < NUM_CHANNELS; i++) begin
        mtimecmp_q[i] <= mtimecmp_d[i];
      end
    end
  end

  assign mtime      = mtime_q;
  assign mtime_gray = mtime_gray_q;
  assign load_epoch = load_epoch_q;
  assign tick       = tick_q;
  assign mtip       = mtip_q;

endmodule

// File: tb/tb_clint_timebase.sv
// Directed self-checking bench for clint_timebase (two comparator channels).
module tb_clint_timebase;

  logic        timer_clk = 1'b0;
  logic        rstn      = 1'b0;
  logic        cfg_wr    = 1'b0;
  logic [15:0] cfg_num   = '0;
  logic [15:0] cfg_den   = '0;
  logic        halt      = 1'b0;
  logic        load_en   = 1'b0;
  logic [63:0] load_data = '0;
  logic [1:0]  cmp_wr    = '0;
  logic [63:0] cmp_data  = '0;
  logic [63:0] mtime;
  logic [63:0] mtime_gray;
  logic        load_epoch;
  logic        tick;
  logic [1:0]  mtip;

  int checks   = 0;
  int failures = 0;

  clint_timebase #(
    .NUM_CHANNELS(2),
    .TIME_WIDTH  (64),
    .RATIO_WIDTH (16),
    .DEF_NUM     (1),
    .DEF_DEN     (40)
  ) dut (
    .timer_clk (timer_clk),
    .rstn      (rstn),
    .cfg_wr    (cfg_wr),
    .cfg_num   (cfg_num),
    .cfg_den   (cfg_den),
    .halt      (halt),
    .load_en   (load_en),
    .load_data (load_data),
    .cmp_wr    (cmp_wr),
    .cmp_data  (cmp_data),
    .mtime     (mtime),
    .mtime_gray(mtime_gray),
    .load_epoch(load_epoch),
    .tick      (tick),
    .mtip      (mtip)
  );

  always #5 timer_clk = ~timer_clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Advance n rising edges, then settle 1 time unit past the last edge.
  task automatic step(input int n);
    repeat (n) @(posedge timer_clk);
    #1;
  endtask

  task automatic write_cfg(input logic [15:0] n, input logic [15:0] d);
    cfg_num = n;
    cfg_den = d;
    cfg_wr  = 1'b1;
    step(1);
    cfg_wr  = 1'b0;
  endtask

  initial begin
    int tick_cnt;
    int first_tick;
    int last_tick;
    int max_gap;
    int pat_bad;
    logic exp_tick;

    // Reset state
    step(3);
    check("rst_mtime", mtime, 64'd0);
    check("rst_gray", mtime_gray, 64'd0);
    check("rst_epoch", {63'd0, load_epoch}, 64'd0);
    check("rst_tick", {63'd0, tick}, 64'd0);
    check("rst_mtip", {62'd0, mtip}, 64'd0);

    // Defaults: 1/40 ratio, ticks on cycles 40, 80, ... 400
    rstn = 1'b1;
    tick_cnt = 0;
    first_tick = 0;
    for (int c = 1; c <= 400; c++) begin
      step(1);
      if (tick) begin
        tick_cnt++;
        if (first_tick == 0) first_tick = c;
      end
    end
    check("def_first_tick", 64'(first_tick), 64'd40);
    check("def_tick_count", 64'(tick_cnt), 64'd10);
    check("def_mtime", mtime, 64'd10);
    check("def_gray", mtime_gray, 64'hF);
    check("def_mtip", {62'd0, mtip}, 64'd0);

    // 3/8 ratio: ticks at cycle%8 in {3,6,0}
    write_cfg(16'd3, 16'd8);
    check("cfg38_tick_suppr", {63'd0, tick}, 64'd0);
    tick_cnt = 0;
    last_tick = 0;
    max_gap = 0;
    pat_bad = 0;
    for (int c = 1; c <= 80; c++) begin
      step(1);
      exp_tick = (c % 8 == 3) || (c % 8 == 6) || (c % 8 == 0);
      if (tick !== exp_tick) pat_bad++;
      if (tick) begin
        tick_cnt++;
        if (c - last_tick > max_gap) max_gap = c - last_tick;
        last_tick = c;
      end
    end
    check("r38_pattern_errs", 64'(pat_bad), 64'd0);
    check("r38_tick_count", 64'(tick_cnt), 64'd30);
    check("r38_max_gap_le3", 64'(max_gap <= 3), 64'd1);
    check("r38_mtime", mtime, 64'd40);

    // num=den=1 with load near wrap
    write_cfg(16'd1, 16'd1);
    check("cfg11_mtime_hold", mtime, 64'd40);
    load_en   = 1'b1;
    load_data = 64'hFFFF_FFFF_FFFF_FFFE;
    step(1);
    load_en   = 1'b0;
    check("wrap_ld_mtime", mtime, 64'hFFFF_FFFF_FFFF_FFFE);
    check("wrap_ld_gray", mtime_gray, 64'h8000_0000_0000_0001);
    check("wrap_ld_tick", {63'd0, tick}, 64'd0);
    check("wrap_ld_epoch", {63'd0, load_epoch}, 64'd1);
    step(1);
    check("wrap_ff_mtime", mtime, 64'hFFFF_FFFF_FFFF_FFFF);
    check("wrap_ff_gray", mtime_gray, 64'h8000_0000_0000_0000);
    check("wrap_ff_tick", {63'd0, tick}, 64'd1);
    step(1);
    check("wrap_0_mtime", mtime, 64'd0);
    check("wrap_0_gray", mtime_gray, 64'd0);
    check("wrap_0_tick", {63'd0, tick}, 64'd1);
    step(1);
    check("wrap_1_mtime", mtime, 64'd1);
    check("wrap_1_tick", {63'd0, tick}, 64'd1);
    check("wrap_1_epoch", {63'd0, load_epoch}, 64'd1);

    // Back to 1/40: old-ratio tick in the cfg cycle is suppressed
    write_cfg(16'd1, 16'd40);
    check("cfg140_suppr_mtime", mtime, 64'd1);
    check("cfg140_suppr_tick", {63'd0, tick}, 64'd0);
    step(39);
    check("pre_coinc_mtime", mtime, 64'd1);
    // Load coincident with the 40th-cycle tick event
    load_en   = 1'b1;
    load_data = 64'h1234;
    step(1);
    load_en   = 1'b0;
    check("coinc_mtime", mtime, 64'h1234);
    check("coinc_tick", {63'd0, tick}, 64'd0);
    check("coinc_epoch", {63'd0, load_epoch}, 64'd0);
    step(39);
    check("coinc_next_pre", mtime, 64'h1234);
    step(1);
    check("coinc_next_mtime", mtime, 64'h1235);
    check("coinc_next_tick", {63'd0, tick}, 64'd1);

    // Comparator: load mtime=0 and mtimecmp[0]=5 together (acc -> 1)
    load_en   = 1'b1;
    load_data = 64'd0;
    cmp_wr    = 2'b01;
    cmp_data  = 64'd5;
    step(1);
    load_en   = 1'b0;
    cmp_wr    = 2'b00;
    step(198);
    check("cmp_pre_mtime", mtime, 64'd4);
    check("cmp_pre_mtip", {62'd0, mtip}, 64'd0);
    step(1);
    check("cmp_eq_mtime", mtime, 64'd5);
    check("cmp_eq_mtip_lat", {62'd0, mtip}, 64'd0);
    step(1);
    check("cmp_eq_mtip", {62'd0, mtip}, 64'd1);
    cmp_wr   = 2'b01;
    cmp_data = 64'd100;
    step(1);
    cmp_wr   = 2'b00;
    check("cmp_raise_lat", {62'd0, mtip}, 64'd1);
    step(1);
    check("cmp_raise_mtip", {62'd0, mtip}, 64'd0);
    cmp_wr   = 2'b11;
    cmp_data = 64'd0;
    step(1);
    cmp_wr   = 2'b00;
    step(1);
    check("cmp_both_mtip", {62'd0, mtip}, 64'd3);
    // acc is now 5 (5 cycles since the tick that produced mtime=5)

    // Halt for 200 cycles; load still works while halted
    halt = 1'b1;
    tick_cnt = 0;
    for (int c = 1; c <= 200; c++) begin
      if (c == 100) begin
        load_en   = 1'b1;
        load_data = 64'd7;
      end
      step(1);
      load_en = 1'b0;
      if (tick) tick_cnt++;
      if (c == 99) check("halt_mtime_frozen", mtime, 64'd5);
    end
    check("halt_tick_count", 64'(tick_cnt), 64'd0);
    check("halt_load_mtime", mtime, 64'd7);
    halt = 1'b0;
    // acc resumes from 5: next tick after 35 cycles
    step(34);
    check("resume_pre_mtime", mtime, 64'd7);
    check("resume_pre_tick", {63'd0, tick}, 64'd0);
    step(1);
    check("resume_mtime", mtime, 64'd8);
    check("resume_tick", {63'd0, tick}, 64'd1);

    // den=0 stops ticking
    write_cfg(16'd1, 16'd0);
    tick_cnt = 0;
    for (int c = 1; c <= 100; c++) begin
      step(1);
      if (tick) tick_cnt++;
    end
    check("den0_tick_count", 64'(tick_cnt), 64'd0);
    check("den0_mtime", mtime, 64'd8);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/clint_timebase.md
Name: clint_timebase

Overview:
- Next-generation CLINT time keeper, running entirely in the timer_clk domain.
- Generates the mtime tick from any timer_clk frequency with a programmable fractional (num/den) divider, replacing the fixed integer divider.
- Maintains mtime with load and halt support, compares it against NUM_CHANNELS mtimecmp registers, and drives registered mtip.
- Exports a Gray-coded mtime copy so the bus-clock CLINT front end can sample it safely across the clock crossing.

Parameters:
- NUM_CHANNELS, 1, number of harts/comparators (1..4094).
- TIME_WIDTH, 64, width of mtime and mtimecmp.
- RATIO_WIDTH, 16, width of cfg_num and cfg_den.
- DEF_NUM, 1, reset numerator.
- DEF_DEN, 40, reset denominator (40 MHz timer_clk gives a 1 MHz tick).

Ports:
- timer_clk  in  1  clock
- rstn  in  1  asynchronous active-low reset
- cfg_wr  in  1  pulse: latch cfg_num/cfg_den
- cfg_num  in  RATIO_WIDTH  tick numerator
- cfg_den  in  RATIO_WIDTH  tick denominator
- halt  in  1  level: freeze mtime and the accumulator (debug stop-count)
- load_en  in  1  pulse: overwrite mtime
- load_data  in  TIME_WIDTH  new mtime value
- cmp_wr  in  NUM_CHANNELS  per-channel mtimecmp write strobe
- cmp_data  in  TIME_WIDTH  mtimecmp write data, shared by all channels
- mtime  out  TIME_WIDTH  current time, binary
- mtime_gray  out  TIME_WIDTH  Gray(mtime), registered, aligned with mtime
- load_epoch  out  1  toggles on every accepted load_en
- tick  out  1  high for the one cycle in which mtime incremented
- mtip  out  NUM_CHANNELS  timer interrupt pending, registered

Behaviour:
- Reset (async, rstn low), all registers:
  - num=DEF_NUM, den=DEF_DEN, acc=0;
  - mtime=0, mtime_gray=0, load_epoch=0, tick=0;
  - every mtimecmp = all-ones;
  - mtip=0.
- Reset asserted mid-operation discards any in-flight state immediately; no partial updates survive.
- Divider (acc is RATIO_WIDTH+1 bits; evaluated each cycle when halt=0 and cfg_wr=0):
  - den==0: no tick; acc holds.
  - num>=den: tick every cycle; acc=0.
  - Otherwise compute s=acc+num:
    - s>=den: acc<=s-den, tick event.
    - else: acc<=s, no tick.
  - Long-run tick rate = f_timer_clk*num/den, exact with no drift.
- cfg_wr: num/den latched and acc cleared the same cycle. Any tick event from the old ratio in that cycle is suppressed. The new ratio applies from the next cycle.
- Halt:
  - halt=1: acc and mtime hold, tick=0.
  - cmp_wr and load_en remain functional while halted.
- mtime update priority per cycle:
  - load_en wins: mtime<=load_data, tick=0, load_epoch toggles. A coincident divider tick event is dropped, but acc still advances.
  - Else tick event: mtime<=mtime+1, wrapping all-ones to 0; tick=1 for one cycle.
  - Else hold.
- mtime_gray is computed from the next mtime value, so mtime and mtime_gray always change in the same cycle. On increment exactly one Gray bit flips. The consumer re-synchronises whenever load_epoch changes.
- mtimecmp[i]<=cmp_data when cmp_wr[i]; multiple strobes in one cycle are legal.
- mtip[i]<=(mtimecmp[i] <= mtime), unsigned, using the registered values.
  - Latency: one cycle after mtime or mtimecmp changes.
  - mtip is a level, not sticky: it clears one cycle after mtimecmp is raised above mtime or mtime wraps below it.
- Elaboration error if NUM_CHANNELS is outside 1..4094, or if DEF_DEN==0.

Test Plan:
- Reset, then 400 cycles at defaults -> tick every 40th cycle (cycles 40, 80, ...); mtime=10; mtime_gray=0xF; mtip=0.
- cfg_wr with num=3, den=8, run 80 cycles -> exactly 30 ticks; tick pattern repeats every 8 cycles, 3 ticks per period; no two ticks more than 3 cycles apart.
- load_data=0xFFFF_FFFF_FFFF_FFFE with num=den=1 -> mtime reads ...FE, ...FF, 0, 1 on consecutive cycles; tick high each cycle; load_epoch toggled once.
- load_en coincident with a divider tick event -> mtime equals load_data exactly, not +1; tick=0 that cycle; the next tick arrives on schedule.
- cmp_wr[0] with mtimecmp=5 at defaults -> mtip[0] rises one cycle after mtime reaches 5. Rewriting mtimecmp=100 -> mtip[0] falls one cycle later.
- halt=1 for 200 cycles mid-count -> mtime and tick frozen. Release -> counting resumes with the preserved acc phase; set cfg_den=0 -> no further ticks.
